// File: rtl/vga_scanout_pkg.sv
// Shared 640x480@60 timing constants, framebuffer geometry and small helpers for the scanout.
// Pure declarations: no latency, no flow control.
package vga_scanout_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BACK;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BACK;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_WIDTH    = 160;
  localparam int ADDR_W      = 15;
  localparam int COLOR_W     = 3;
  localparam int DAC_W       = 10;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

  // by*160 + bx built from two shifts (128 + 32) so no multiplier is inferred.
  function automatic fb_addr_t fb_addr(input logic [7:0] bx, input logic [6:0] by);
    fb_addr_t y;
    y = fb_addr_t'(by);
    return (y << 7) + (y << 5) + fb_addr_t'(bx);
  endfunction

  function automatic color_t bar_index(input logic [9:0] h);
    color_t k;
    k = '0;
    for (int i = 1; i < 8; i++) begin
      if (h >= 10'(i * 80)) k = k + 3'd1;
    end
    return k;
  endfunction

endpackage

// File: rtl/vga_scanout_timing_gen.sv
// Pixel-enable divider, h/v raster counters and raw (stage-0) sync, active and frame flags.
// Flags are combinational from the counters; counters advance on clocks where pix_en is high.
module vga_scanout_timing_gen
  import vga_scanout_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [7:0]  bx,
  output logic [6:0]  by,
  output color_t      bar,
  output logic        hs_n,
  output logic        vs_n,
  output logic        active,
  output logic        frame_start,
  output logic        vblank
);

  logic [9:0] hcount;
  logic [9:0] vcount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_TOTAL - 10'd1) begin
          hcount <= '0;
          vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  assign hs_n        = ~((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vs_n        = ~((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
  assign active      = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
  assign vblank      = (vcount >= V_ACTIVE);
  assign frame_start = pix_en && (hcount == '0) && (vcount == '0);

  // Buffer coordinates only matter inside the active area, where vcount < 480 fits in [8:0].
  assign bx  = hcount[9:SCALE_SHIFT];
  assign by  = vcount[8:SCALE_SHIFT];
  assign bar = bar_index(hcount);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer-to-VGA scanout: address issue at stage 0, colour/sync/blank registered one tick later.
// Outputs lag the counters by two pixel ticks; no backpressure. Optional bars: SCANOUT_TEST_PATTERN_EN.
module vga_scanout
  import vga_scanout_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_en,
  input  logic [COLOR_W-1:0] rd_data,
  input  logic               test_pattern,
  output logic               frame_start,
  output logic               in_vblank,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [DAC_W-1:0]   VGA_R,
  output logic [DAC_W-1:0]   VGA_G,
  output logic [DAC_W-1:0]   VGA_B
);

  logic       pix_en;
  logic       active;
  logic       hs_n;
  logic       vs_n;
  logic [7:0] bx;
  logic [6:0] by;
  color_t     bar;
  logic       use_pat;
  fb_addr_t   addr_now;
  fb_addr_t   addr_q;
  sync_t      s1;
  sync_t      out_q;
  color_t     col_next;
  color_t     col_q;
  logic       vga_clk_q;

  vga_scanout_timing_gen u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .bx          (bx),
    .by          (by),
    .bar         (bar),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .active      (active),
    .frame_start (frame_start),
    .vblank      (in_vblank)
  );

  assign addr_now = fb_addr(bx, by);
  assign rd_en    = pix_en & active & ~use_pat;
  // Address is only meaningful with rd_en; otherwise present the last issued one.
  assign rd_addr  = rd_en ? addr_now : addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_q <= '0;
    else if (rd_en) addr_q <= addr_now;
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  logic   s1_pat;
  color_t s1_bar;

  assign use_pat = test_pattern;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_pat <= 1'b0;
      s1_bar <= '0;
    end else if (pix_en) begin
      s1_pat <= test_pattern;
      s1_bar <= bar;
    end
  end

  assign col_next = !s1.active ? '0 : (s1_pat ? s1_bar : rd_data);
`else
  logic unused_pattern_inputs;

  assign unused_pattern_inputs = ^{test_pattern, bar};
  assign use_pat               = 1'b0;
  assign col_next              = s1.active ? rd_data : '0;
`endif

  // s1 holds stage-0 flags while the RAM read is in flight; out_q lines them up with rd_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= SYNC_IDLE;
      out_q     <= SYNC_IDLE;
      col_q     <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      vga_clk_q <= pix_en;
      if (pix_en) begin
        s1    <= '{hs_n: hs_n, vs_n: vs_n, active: active};
        out_q <= s1;
        col_q <= col_next;
      end
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = out_q.hs_n;
  assign VGA_VS      = out_q.vs_n;
  assign VGA_BLANK_N = out_q.active;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {DAC_W{col_q[2]}};
  assign VGA_G       = {DAC_W{col_q[1]}};
  assign VGA_B       = {DAC_W{col_q[0]}};

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: random framebuffer contents and reset points checked cycle by cycle
// against a raster model derived from pixel index arithmetic.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        test_pattern = 1'b0;
  logic [2:0]  rd_data;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic        frame_start;
  logic        in_vblank;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [9:0]  VGA_R;
  logic [9:0]  VGA_G;
  logic [9:0]  VGA_B;

  always #10 clk = ~clk;

  vga_scanout dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .test_pattern (test_pattern),
    .frame_start  (frame_start),
    .in_vblank    (in_vblank),
    .VGA_CLK      (VGA_CLK),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_BLANK_N  (VGA_BLANK_N),
    .VGA_SYNC_N   (VGA_SYNC_N),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  // Synchronous framebuffer with one clock of read latency.
  logic [2:0] mem [0:19199];
  logic [2:0] ram_q = 3'b000;
  assign rd_data = ram_q;
  always @(posedge clk) if (rd_en) ram_q <= mem[rd_addr];

  typedef struct packed {
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        sync_n;
    logic        fs;
    logic        vb;
    logic        rd_en;
    logic [14:0] addr;
    logic [29:0] rgb;
  } exp_t;

  exp_t obs;
  assign obs = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start, in_vblank,
                rd_en, rd_addr, VGA_R, VGA_G, VGA_B};

  int total = 0;
  int bad = 0;
  int m = 0;      // clock edges since reset release
  bit pat_mode = 1'b0;

  function automatic bit px_active(int p);
    int h = p % 800;
    int v = (p / 800) % 525;
    return (h < 640) && (v < 480);
  endfunction

  function automatic logic [14:0] px_addr(int p);
    int h = p % 800;
    int v = (p / 800) % 525;
    return 15'((v / 4) * 160 + (h / 4));
  endfunction

  // Pixel p is presented at stage 0 on edge 2p+1 and appears on the pins after edge 2p+4.
  function automatic exp_t model(int mm);
    exp_t e;
    int c, h, v, jo;
    bit pix, usepat;
    logic [2:0] col;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.sync_n = 1'b1;
    usepat = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
    usepat = pat_mode;
`endif
    c = mm / 2;
    pix = (mm % 2) == 1;
    e.vclk = (mm > 0) && ((mm % 2) == 0);
    e.vb = ((c / 800) % 525) >= 480;
    e.fs = pix && ((c % 420000) == 0);
    e.rd_en = pix && px_active(c) && !usepat;
    if (mm >= 1 && !usepat) begin
      for (int p = (mm - 1) / 2; p >= 0 && p > (mm - 1) / 2 - 1000; p--) begin
        if (px_active(p)) begin
          e.addr = px_addr(p);
          break;
        end
      end
    end
    if (mm >= 4) begin
      jo = mm / 2 - 2;
      h = jo % 800;
      v = (jo / 800) % 525;
      e.hs = !(h >= 656 && h < 752);
      e.vs = !(v >= 490 && v < 492);
      e.blank_n = px_active(jo);
      col = 3'b000;
      if (px_active(jo)) col = usepat ? 3'(h / 80) : mem[px_addr(jo)];
      e.rgb = {{10{col[2]}}, {10{col[1]}}, {10{col[0]}}};
    end
    return e;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
    m = m + 1;
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    e = model(0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    reset = 1'b0;
    m = 0;
    #1;
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs, e);
    end
    step;
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL frame_start_first got=%b exp=1", frame_start);
    end
    step;
    total++;
    if (frame_start !== 1'b0) begin
      bad++;
      $display("FAIL frame_start_width got=%b exp=0", frame_start);
    end
  endtask

  task automatic test_scan;
    exp_t e;
    int fall1 = -1, fall2 = -1, rise1 = -1, brise = -1;
    logic prev_hs = 1'b1;
    logic prev_blank = 1'b0;
    while (m < 6800) begin
      step;
      e = model(m);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL scan m=%0d got=%h exp=%h", m, obs, e);
      end
      if (m == 4) begin
        total++;
        if ({VGA_R, VGA_G, VGA_B} !== 30'h0 || VGA_BLANK_N !== 1'b1) begin
          bad++;
          $display("FAIL pixel_0_0 got=%h blank=%b exp=0 blank=1", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N);
        end
      end
      if (m == 44) begin
        total++;
        if (VGA_R !== 10'h3FF || VGA_G !== 10'h000 || VGA_B !== 10'h3FF || VGA_BLANK_N !== 1'b1) begin
          bad++;
          $display("FAIL pixel_20_0 got=%h/%h/%h blank=%b exp=3ff/000/3ff blank=1", VGA_R, VGA_G, VGA_B, VGA_BLANK_N);
        end
      end
      if (m == 1281) begin
        total++;
        if (rd_en !== 1'b0) begin
          bad++;
          $display("FAIL rd_en_h640 got=%b exp=0", rd_en);
        end
      end
      if (m == 6409) begin
        total++;
        if (rd_en !== 1'b1 || rd_addr !== 15'd161) begin
          bad++;
          $display("FAIL addr_4_4 got=%0d en=%b exp=161 en=1", rd_addr, rd_en);
        end
      end
      if (prev_hs && !VGA_HS) begin
        if (fall1 < 0) fall1 = m;
        else if (fall2 < 0) fall2 = m;
      end
      if (!prev_hs && VGA_HS && rise1 < 0 && fall1 >= 0) rise1 = m;
      if (!prev_blank && VGA_BLANK_N && brise < 0) brise = m;
      prev_hs = VGA_HS;
      prev_blank = VGA_BLANK_N;
      if (bad > 40) break;
    end
    total++;
    if (fall2 - fall1 !== 1600) begin
      bad++;
      $display("FAIL hs_period got=%0d exp=1600", fall2 - fall1);
    end
    total++;
    if (rise1 - fall1 !== 192) begin
      bad++;
      $display("FAIL hs_low_width got=%0d exp=192", rise1 - fall1);
    end
    total++;
    if (fall1 - brise !== 1312) begin
      bad++;
      $display("FAIL hs_offset got=%0d exp=1312", fall1 - brise);
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    int run;
    repeat (3) begin
      run = $urandom_range(300, 1500);
      repeat (run) step;
      reset = 1'b1;
      #1;
      e = model(0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_reset_async run=%0d got=%h exp=%h", run, obs, e);
      end
      @(posedge clk);
      #1;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_reset_next_clk got=%h exp=%h", obs, e);
      end
      test_pattern = 1'($urandom_range(0, 1));
`ifdef SCANOUT_TEST_PATTERN_EN
      pat_mode = test_pattern;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m = 0;
      for (int k = 0; k < 1700; k++) begin
        step;
        e = model(m);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL restart m=%0d pat=%b got=%h exp=%h", m, test_pattern, obs, e);
        end
        if (bad > 40) break;
      end
    end
    test_pattern = 1'b0;
    pat_mode = 1'b0;
  endtask

`ifdef SCANOUT_TEST_PATTERN_EN
  task automatic test_pattern_bars;
    exp_t e;
    int rd_seen = 0;
    reset = 1'b1;
    test_pattern = 1'b1;
    pat_mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m = 0;
    while (m < 1700) begin
      step;
      e = model(m);
      if (rd_en) rd_seen++;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL bars m=%0d got=%h exp=%h", m, obs, e);
      end
      if (m == 504) begin
        total++;
        if (VGA_R !== 10'h000 || VGA_G !== 10'h3FF || VGA_B !== 10'h3FF) begin
          bad++;
          $display("FAIL bar3_h250 got=%h/%h/%h exp=000/3ff/3ff", VGA_R, VGA_G, VGA_B);
        end
      end
      if (bad > 40) break;
    end
    total++;
    if (rd_seen !== 0) begin
      bad++;
      $display("FAIL bars_rd_en got=%0d exp=0", rd_seen);
    end
    test_pattern = 1'b0;
    pat_mode = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
    mem[0] = 3'b000;
    mem[5] = 3'b101;
    test_reset;
    test_scan;
    test_mid_reset;
`ifdef SCANOUT_TEST_PATTERN_EN
    test_pattern_bars;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
